// File: rtl/sfx_pkg.sv
// Shared definitions for the sound-effect playback scheduler.
//   - clip ids (higher id = higher priority)
//   - clip address table, end address inclusive
//   - scheduler FSM state encoding
package sfx_pkg;

  localparam int SFX_ADDR_W        = 23;
  localparam int SFX_DATA_W        = 8;
  localparam int SFX_NREQ          = 4;
  localparam int SFX_FETCH_TIMEOUT = 255;

  localparam logic [1:0] SFX_MUSIC    = 2'd0;
  localparam logic [1:0] SFX_WHACK    = 2'd1;
  localparam logic [1:0] SFX_MISS     = 2'd2;
  localparam logic [1:0] SFX_GAMEOVER = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SELECT    = 3'd1,
    ST_WAIT_TICK = 3'd2,
    ST_FETCH     = 3'd3,
    ST_WAIT_DATA = 3'd4
  } sfx_state_e;

  // First sample address of each clip.
  function automatic logic [SFX_ADDR_W-1:0] clip_start(input logic [1:0] id);
    case (id)
      SFX_MUSIC: clip_start = 23'h00_8B00;
      SFX_WHACK: clip_start = 23'h00_0100;
      SFX_MISS:  clip_start = 23'h00_0200;
      default:   clip_start = 23'h00_0300;
    endcase
  endfunction

  // Last sample address of each clip (inclusive).
  function automatic logic [SFX_ADDR_W-1:0] clip_end(input logic [1:0] id);
    case (id)
      SFX_MUSIC: clip_end = 23'h00_8B0F;
      SFX_WHACK: clip_end = 23'h00_0102;
      SFX_MISS:  clip_end = 23'h00_0203;
      default:   clip_end = 23'h00_0303;
    endcase
  endfunction

endpackage

// File: rtl/sfx_playback_scheduler_pick.sv
// sfx_priority_pick: combinational highest-set-bit encoder over the pending mask.
//   pend_i  : pending request bits, bit i = clip id i
//   valid_o : at least one bit pending
//   id_o    : index of the highest pending bit (0 when none)
module sfx_priority_pick
  import sfx_pkg::*;
#(
  parameter int NREQ = SFX_NREQ
) (
  input  logic [NREQ-1:0] pend_i,
  output logic            valid_o,
  output logic [1:0]      id_o
);

  always_comb begin
    valid_o = |pend_i;
    id_o    = '0;
    // Later iterations overwrite earlier ones, so the highest set bit wins.
    for (int i = 0; i < NREQ; i++) begin
      if (pend_i[i]) id_o = 2'(i);
    end
  end

endmodule

// File: rtl/sfx_playback_scheduler.sv
// sfx_playback_scheduler: shares the single sample-ROM read path among music and
// three effects. One ROM read per sample tick; effects preempt music, music
// resumes from where it paused.
//   clk, reset        : clock, synchronous active-high reset
//   sample_tick_i     : one-clk pulse at the sample rate
//   req_i             : one-clk request pulse per clip id
//   stop_i            : one-clk abort, go silent
//   mem_addr_o/rd_o   : ROM read address and one-clk read strobe
//   mem_valid_i/data_i: ROM read return
//   audio_out_o       : current sample, held between ticks
//   playing_o/_id_o   : a clip is active / which one (0 when idle)
//   clip_done_o       : one-clk pulse after the last sample of a clip returns
//   fetch_error_o     : one-clk pulse when a read is abandoned
//   music_address_o   : music pointer, frozen while paused, 0 when music inactive
//   state_o           : FSM state for observation
//
// ROM handshake: mem_rd_o is a one-cycle strobe with mem_addr_o valid in the same
// cycle; exactly one read is outstanding at a time. The ROM answers with a
// one-cycle mem_valid_i pulse carrying mem_data_i. A mem_valid_i that arrives
// outside WAIT_DATA (after stop, reset or timeout) is ignored.
module sfx_playback_scheduler
  import sfx_pkg::*;
#(
  parameter int ADDR_W        = SFX_ADDR_W,
  parameter int DATA_W        = SFX_DATA_W,
  parameter int NREQ          = SFX_NREQ,
  parameter int FETCH_TIMEOUT = SFX_FETCH_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic              stop_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic              mem_valid_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] audio_out_o,
  output logic              playing_o,
  output logic [1:0]        playing_id_o,
  output logic              clip_done_o,
  output logic              fetch_error_o,
  output logic [ADDR_W-1:0] music_address_o,
  output logic [2:0]        state_o
);

  localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  sfx_state_e        state_q, state_d;
  logic [NREQ-1:0]   pend_q, pend_d, req_eff, clr;
  logic              music_active_q, music_active_d;
  logic [ADDR_W-1:0] music_addr_q, music_addr_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [1:0]        cur_id_q, cur_id_d;
  logic [DATA_W-1:0] audio_q, audio_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              retrig_q, retrig_d;
  logic              clip_done_q, clip_done_d;
  logic              fetch_error_q, fetch_error_d;
  logic              pick_valid, finish;
  logic [1:0]        pick_id;

  sfx_priority_pick #(.NREQ(NREQ)) u_pick (
    .pend_i  (pend_q),
    .valid_o (pick_valid),
    .id_o    (pick_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      pend_q         <= '0;
      music_active_q <= 1'b0;
      music_addr_q   <= '0;
      ptr_q          <= '0;
      cur_id_q       <= '0;
      audio_q        <= MIDSCALE;
      cnt_q          <= '0;
      retrig_q       <= 1'b0;
      clip_done_q    <= 1'b0;
      fetch_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      music_active_q <= music_active_d;
      music_addr_q   <= music_addr_d;
      ptr_q          <= ptr_d;
      cur_id_q       <= cur_id_d;
      audio_q        <= audio_d;
      cnt_q          <= cnt_d;
      retrig_q       <= retrig_d;
      clip_done_q    <= clip_done_d;
      fetch_error_q  <= fetch_error_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    music_active_d = music_active_q;
    music_addr_d   = music_addr_q;
    ptr_d          = ptr_q;
    cur_id_d       = cur_id_q;
    audio_d        = audio_q;
    cnt_d          = cnt_q;
    retrig_d       = retrig_q;
    clip_done_d    = 1'b0;
    fetch_error_d  = 1'b0;
    clr            = '0;
    finish         = 1'b0;

    // A music request while music is active (playing or paused) is meaningless.
    req_eff            = req_i;
    req_eff[SFX_MUSIC] = req_i[SFX_MUSIC] & ~music_active_q;

    // A repeat request for the effect on air restarts it at the next WAIT_TICK.
    if ((state_q inside {ST_WAIT_TICK, ST_FETCH, ST_WAIT_DATA}) &&
        (cur_id_q != SFX_MUSIC) && req_i[cur_id_q])
      retrig_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        audio_d  = MIDSCALE;
        cur_id_d = SFX_MUSIC;
        if (|pend_q) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        retrig_d = 1'b0;
        if (pick_valid) begin
          cur_id_d = pick_id;
          if (pick_id == SFX_MUSIC) begin
            music_active_d = 1'b1;
            if (music_active_q) begin
              ptr_d = music_addr_q;   // resume where the music was paused
            end else begin
              ptr_d        = ADDR_W'(clip_start(pick_id));
              music_addr_d = ADDR_W'(clip_start(pick_id));
            end
          end else begin
            ptr_d = ADDR_W'(clip_start(pick_id));
          end
          state_d = ST_WAIT_TICK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_TICK: begin
        if (pick_valid && (pick_id > cur_id_q)) begin
          // Preempted effects are dropped; preempted music keeps its pend bit and pointer.
          if (cur_id_q != SFX_MUSIC) clr[cur_id_q] = 1'b1;
          state_d = ST_SELECT;
        end else if (retrig_q) begin
          state_d = ST_SELECT;
        end else if (sample_tick_i) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // The counter starts at the strobe so the timeout is measured from mem_rd.
        cnt_d   = CNT_W'(1);
        state_d = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (mem_valid_i) begin
          audio_d = mem_data_i;
          if (ptr_q == ADDR_W'(clip_end(cur_id_q))) begin
            clip_done_d = 1'b1;
            finish      = 1'b1;
            if (!retrig_q) clr[cur_id_q] = 1'b1;
            if (cur_id_q == SFX_MUSIC) begin
              music_active_d = 1'b0;
              music_addr_d   = '0;
            end
          end else begin
            ptr_d = ptr_q + 1'b1;
            if (cur_id_q == SFX_MUSIC) music_addr_d = ptr_q + 1'b1;
            state_d = ST_WAIT_TICK;
          end
        end else if (cnt_q == CNT_W'(FETCH_TIMEOUT - 1)) begin
          fetch_error_d = 1'b1;
          finish        = 1'b1;
          clr[cur_id_q] = 1'b1;
          if (cur_id_q == SFX_MUSIC) begin
            music_active_d = 1'b0;
            music_addr_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clears apply before new requests so a request in the finishing cycle survives.
    pend_d = (pend_q & ~clr) | req_eff;

    if (finish) begin
      retrig_d = 1'b0;
      if (|pend_d) begin
        state_d = ST_SELECT;
      end else begin
        state_d  = ST_IDLE;
        cur_id_d = SFX_MUSIC;
      end
    end

    if (stop_i) begin
      state_d        = ST_IDLE;
      pend_d         = '0;
      music_active_d = 1'b0;
      music_addr_d   = '0;
      audio_d        = MIDSCALE;
      cur_id_d       = SFX_MUSIC;
      retrig_d       = 1'b0;
      clip_done_d    = 1'b0;
      fetch_error_d  = 1'b0;
    end
  end

  assign mem_rd_o        = (state_q == ST_FETCH);
  assign mem_addr_o      = mem_rd_o ? ptr_q : '0;
  assign audio_out_o     = audio_q;
  assign playing_o       = (state_q != ST_IDLE);
  assign playing_id_o    = cur_id_q;
  assign clip_done_o     = clip_done_q;
  assign fetch_error_o   = fetch_error_q;
  assign music_address_o = music_addr_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_sfx_playback_scheduler.sv
// Bench for sfx_playback_scheduler: behavioural ROM with programmable latency,
// a tick generator, and an expected-address queue consumed as reads appear.
module tb_sfx_playback_scheduler;

  localparam int AW = 23;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_tick_i = 1'b0;
  logic [3:0]    req_i = '0;
  logic          stop_i = 1'b0;
  logic          mem_valid_i = 1'b0;
  logic [DW-1:0] mem_data_i = '0;
  logic [AW-1:0] mem_addr_o;
  logic          mem_rd_o;
  logic [DW-1:0] audio_out_o;
  logic          playing_o;
  logic [1:0]    playing_id_o;
  logic          clip_done_o;
  logic          fetch_error_o;
  logic [AW-1:0] music_address_o;
  logic [2:0]    state_o;

  logic [AW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int tick_period = 0;
  int tick_count = 0;
  int mem_lat = 2;
  int mem_cnt = 0;
  logic withhold = 1'b0;
  logic [AW-1:0] mem_addr_lat = '0;
  int rd_count = 0;
  int done_count = 0;
  int err_count = 0;

  sfx_playback_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .sample_tick_i   (sample_tick_i),
    .req_i           (req_i),
    .stop_i          (stop_i),
    .mem_addr_o      (mem_addr_o),
    .mem_rd_o        (mem_rd_o),
    .mem_valid_i     (mem_valid_i),
    .mem_data_i      (mem_data_i),
    .audio_out_o     (audio_out_o),
    .playing_o       (playing_o),
    .playing_id_o    (playing_id_o),
    .clip_done_o     (clip_done_o),
    .fetch_error_o   (fetch_error_o),
    .music_address_o (music_address_o),
    .state_o         (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Tick generator and ROM response, driven just after the active edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    sample_tick_i = (tick_period > 0) && ((cyc % tick_period) == 0);
    if (sample_tick_i) tick_count++;
    mem_valid_i = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_valid_i = 1'b1;
        mem_data_i  = mem_addr_lat[7:0] ^ mem_addr_lat[15:8] ^ 8'h3C;
      end
    end
  end

  // Read capture and event counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_rd_o) begin
      rd_count++;
      if (!withhold) begin
        mem_cnt      = mem_lat;
        mem_addr_lat = mem_addr_o;
      end
    end
    if (clip_done_o) done_count++;
    if (fetch_error_o) err_count++;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_req(input logic [3:0] m);
    @(posedge clk); #1 req_i = m;
    @(posedge clk); #1 req_i = '0;
  endtask

  task automatic wait_rd(input int limit, output logic got);
    got = 1'b0;
    for (int t = 0; t < limit && !got; t++) begin
      @(negedge clk);
      got = mem_rd_o;
    end
  endtask

  task automatic wait_valid(input int limit, output logic got);
    got = 1'b0;
    for (int t = 0; t < limit && !got; t++) begin
      @(negedge clk);
      got = mem_valid_i;
    end
  endtask

  task automatic push_range(input logic [AW-1:0] first, input logic [AW-1:0] last);
    for (logic [AW-1:0] a = first; a <= last; a++) exp_q.push_back(a);
  endtask

  // Scoreboard consumer: each read must match the queue head, and the returned
  // byte must appear on audio_out the cycle after mem_valid.
  task automatic drain_reads(input string tag, input int n);
    logic got;
    logic [AW-1:0] ea;
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      wait_rd(400, got);
      ea = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      n_checks++;
      if (!got || mem_addr_o !== ea) begin
        n_fail++;
        $display("FAIL %s_addr[%0d]: seen=%0b addr=%h expected %h", tag, i, got, mem_addr_o, ea);
      end
      if (got) begin
        wait_valid(20, got);
        d = mem_data_i;
        @(negedge clk);
        n_checks++;
        if (!got || audio_out_o !== d) begin
          n_fail++;
          $display("FAIL %s_audio[%0d]: valid=%0b audio=%h expected %h", tag, i, got, audio_out_o, d);
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (audio_out_o !== 8'h80) begin
      n_fail++; $display("FAIL reset_audio: got %h expected 80", audio_out_o);
    end
    n_checks++;
    if ({playing_o, playing_id_o, mem_rd_o, clip_done_o, fetch_error_o, state_o} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0",
               {playing_o, playing_id_o, mem_rd_o, clip_done_o, fetch_error_o, state_o});
    end
    n_checks++;
    if ({mem_addr_o, music_address_o} !== '0) begin
      n_fail++; $display("FAIL reset_addr: mem_addr=%h music=%h expected 0", mem_addr_o, music_address_o);
    end
  endtask

  task automatic test_single_clip();
    int d0;
    tick_period = 40; mem_lat = 2;
    d0 = done_count;
    push_range(23'h100, 23'h102);
    pulse_req(4'b0010);
    drain_reads("t1_whack", 3);
    n_checks++;
    if (clip_done_o !== 1'b1) begin
      n_fail++; $display("FAIL t1_clip_done: got %b expected 1", clip_done_o);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({playing_o, playing_id_o, audio_out_o} !== {1'b0, 2'd0, 8'h80}) begin
      n_fail++; $display("FAIL t1_idle: playing=%b id=%0d audio=%h expected 0 0 80", playing_o, playing_id_o, audio_out_o);
    end
    n_checks++;
    if (done_count - d0 !== 1) begin
      n_fail++; $display("FAIL t1_done_count: got %0d expected 1", done_count - d0);
    end
  endtask

  task automatic test_music_preempt();
    tick_period = 20; mem_lat = 2;
    push_range(23'h8B00, 23'h8B04);
    pulse_req(4'b0001);
    drain_reads("t2_music", 5);
    n_checks++;
    if (music_address_o !== 23'h8B05) begin
      n_fail++; $display("FAIL t2_music_ptr: got %h expected 8b05", music_address_o);
    end
    push_range(23'h200, 23'h203);
    push_range(23'h8B05, 23'h8B0F);
    pulse_req(4'b0100);
    for (int i = 0; i < 4; i++) begin
      drain_reads("t2_miss", 1);
      n_checks++;
      if (music_address_o !== 23'h8B05 || playing_id_o !== 2'd2) begin
        n_fail++; $display("FAIL t2_frozen[%0d]: music=%h id=%0d expected 8b05 2", i, music_address_o, playing_id_o);
      end
    end
    drain_reads("t2_resume", 11);
    repeat (3) @(negedge clk);
    n_checks++;
    if (music_address_o !== '0 || playing_o !== 1'b0) begin
      n_fail++; $display("FAIL t2_end: music=%h playing=%b expected 0 0", music_address_o, playing_o);
    end
  endtask

  task automatic test_simultaneous();
    int d0;
    tick_period = 40; mem_lat = 2;
    d0 = done_count;
    push_range(23'h300, 23'h303);
    push_range(23'h100, 23'h102);
    pulse_req(4'b1010);
    drain_reads("t3_go", 1);
    n_checks++;
    if (playing_id_o !== 2'd3) begin
      n_fail++; $display("FAIL t3_id_go: got %0d expected 3", playing_id_o);
    end
    drain_reads("t3_go", 3);
    drain_reads("t3_whack", 1);
    n_checks++;
    if (playing_id_o !== 2'd1) begin
      n_fail++; $display("FAIL t3_id_whack: got %0d expected 1", playing_id_o);
    end
    drain_reads("t3_whack", 2);
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_count - d0 !== 2 || playing_o !== 1'b0) begin
      n_fail++; $display("FAIL t3_done: count=%0d playing=%b expected 2 0", done_count - d0, playing_o);
    end
  endtask

  task automatic test_effect_preempt();
    int r0;
    tick_period = 20; mem_lat = 2;
    push_range(23'h100, 23'h100);
    pulse_req(4'b0010);
    drain_reads("t4_whack", 1);
    push_range(23'h300, 23'h303);
    pulse_req(4'b1000);
    drain_reads("t4_go", 4);
    @(negedge clk);
    r0 = rd_count;
    repeat (80) @(negedge clk);
    n_checks++;
    if (rd_count !== r0 || playing_o !== 1'b0) begin
      n_fail++; $display("FAIL t4_discard: extra_reads=%0d playing=%b expected 0 0", rd_count - r0, playing_o);
    end
  endtask

  task automatic test_retrigger();
    int d0;
    tick_period = 20; mem_lat = 2;
    d0 = done_count;
    push_range(23'h100, 23'h100);
    pulse_req(4'b0010);
    drain_reads("t5_first", 1);
    push_range(23'h100, 23'h102);
    pulse_req(4'b0010);
    drain_reads("t5_restart", 3);
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_count - d0 !== 1 || playing_o !== 1'b0) begin
      n_fail++; $display("FAIL t5_done: count=%0d playing=%b expected 1 0", done_count - d0, playing_o);
    end
  endtask

  task automatic test_timeout();
    logic got;
    int rd_cyc, d0, e0;
    tick_period = 10; mem_lat = 2; withhold = 1'b1;
    d0 = done_count; e0 = err_count;
    pulse_req(4'b0100);
    wait_rd(100, got);
    rd_cyc = cyc;
    n_checks++;
    if (!got || mem_addr_o !== 23'h200) begin
      n_fail++; $display("FAIL t6_first_rd: seen=%0b addr=%h expected 200", got, mem_addr_o);
    end
    pulse_req(4'b0010);
    got = 1'b0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      got = fetch_error_o;
    end
    withhold = 1'b0;
    n_checks++;
    if (!got || (cyc - rd_cyc) !== 255) begin
      n_fail++; $display("FAIL t6_timeout: seen=%0b delay=%0d expected 255", got, cyc - rd_cyc);
    end
    push_range(23'h100, 23'h102);
    drain_reads("t6_next", 3);
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_count - d0 !== 1 || err_count - e0 !== 1) begin
      n_fail++; $display("FAIL t6_counts: done=%0d err=%0d expected 1 1", done_count - d0, err_count - e0);
    end
  endtask

  task automatic test_stop();
    logic got;
    int r0;
    tick_period = 20; mem_lat = 3;
    push_range(23'h8B00, 23'h8B01);
    pulse_req(4'b0001);
    drain_reads("t7_music", 2);
    wait_rd(100, got);
    n_checks++;
    if (!got || mem_addr_o !== 23'h8B02) begin
      n_fail++; $display("FAIL t7_rd: seen=%0b addr=%h expected 8b02", got, mem_addr_o);
    end
    @(posedge clk); #1 stop_i = 1'b1; req_i = 4'b0010;
    @(posedge clk); #1 stop_i = 1'b0; req_i = '0;
    @(negedge clk);
    r0 = rd_count;
    n_checks++;
    if ({playing_o, music_address_o, audio_out_o} !== {1'b0, 23'h0, 8'h80}) begin
      n_fail++; $display("FAIL t7_stop: playing=%b music=%h audio=%h expected 0 0 80", playing_o, music_address_o, audio_out_o);
    end
    repeat (80) @(negedge clk);
    n_checks++;
    if (rd_count !== r0 || audio_out_o !== 8'h80 || playing_o !== 1'b0) begin
      n_fail++; $display("FAIL t7_quiet: extra_reads=%0d audio=%h playing=%b expected 0 80 0", rd_count - r0, audio_out_o, playing_o);
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic got;
    int r0;
    tick_period = 10; mem_lat = 4;
    pulse_req(4'b0100);
    wait_rd(100, got);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    r0 = rd_count;
    repeat (40) @(negedge clk);
    n_checks++;
    if (!got || rd_count !== r0 || audio_out_o !== 8'h80 || playing_o !== 1'b0) begin
      n_fail++; $display("FAIL t8_reset: seen=%0b extra_reads=%0d audio=%h playing=%b expected 1 0 80 0", got, rd_count - r0, audio_out_o, playing_o);
    end
  endtask

  task automatic test_fast_ticks();
    int t0, r0;
    tick_period = 2; mem_lat = 5;
    push_range(23'h200, 23'h203);
    t0 = tick_count; r0 = rd_count;
    pulse_req(4'b0100);
    drain_reads("t9_fast", 4);
    repeat (3) @(negedge clk);
    n_checks++;
    if (rd_count - r0 !== 4 || (tick_count - t0) <= 8) begin
      n_fail++; $display("FAIL t9_dropped: reads=%0d ticks=%0d expected 4 and >8", rd_count - r0, tick_count - t0);
    end
    tick_period = 0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_clip();
    test_music_preempt();
    test_simultaneous();
    test_effect_preempt();
    test_retrigger();
    test_timeout();
    test_stop();
    test_reset_mid_fetch();
    test_fast_ticks();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL leftover_expected: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
